// File: rtl/index_fetch_unit_if.sv
// Signal bundle for the index fetch unit: controller index handshake, arbitrated memory
// read port and the A/B block stream toward the multiply datapath.
interface index_fetch_unit_if #(
    parameter int unsigned size            = 3,
    parameter int unsigned cell_width      = 32,
    parameter int unsigned index_width     = 8,
    parameter int unsigned memory_size_log = 10
);
    logic                                in_index_ready;
    logic [index_width-1:0]              in_row_index;
    logic [index_width-1:0]              in_col_index;
    logic [index_width-1:0]              in_mu;
    logic [memory_size_log-1:0]          in_a_base;
    logic [memory_size_log-1:0]          in_b_base;
    logic                                out_index_ack;
    logic                                out_request;
    logic                                in_grant;
    logic                                out_mem_read_en;
    logic [memory_size_log-1:0]          out_mem_address;
    logic [size*cell_width-1:0]          in_mem_data;
    logic                                out_block_valid;
    logic                                in_block_ready;
    logic [size*size*cell_width-1:0]     out_a_block;
    logic [size*size*cell_width-1:0]     out_b_block;
    logic [index_width-1:0]              out_k;
    logic                                out_last;
    logic                                out_busy;

    // The fetch unit itself
    modport master (
        input  in_index_ready, in_row_index, in_col_index, in_mu, in_a_base, in_b_base,
        input  in_grant, in_mem_data, in_block_ready,
        output out_index_ack, out_request, out_mem_read_en, out_mem_address,
        output out_block_valid, out_a_block, out_b_block, out_k, out_last, out_busy
    );

    // Controller, arbiter, memory and datapath side
    modport slave (
        output in_index_ready, in_row_index, in_col_index, in_mu, in_a_base, in_b_base,
        output in_grant, in_mem_data, in_block_ready,
        input  out_index_ack, out_request, out_mem_read_en, out_mem_address,
        input  out_block_valid, out_a_block, out_b_block, out_k, out_last, out_busy
    );
endinterface

// File: rtl/index_fetch_unit.sv
// Index fetch unit: latches a (row, col) pair, reads A(row,k) and B(k,col) for k = 0..mu-1
// over the arbitrated memory bus and presents each block pair on a valid/ready stream.
module index_fetch_unit #(
    parameter int unsigned size            = 3,
    parameter int unsigned cell_width      = 32,
    parameter int unsigned index_width     = 8,
    parameter int unsigned memory_size_log = 10
) (
    input logic                in_clk,
    input logic                in_reset,
    index_fetch_unit_if.master bus
);
    localparam int unsigned LineW  = size * cell_width;
    localparam int unsigned BlockW = size * LineW;
    localparam int unsigned ProdW  = 2 * index_width + memory_size_log;
    localparam int unsigned Lines  = 2 * size;
    localparam int unsigned CntW   = (Lines > 1) ? $clog2(Lines) : 1;

    typedef enum logic [2:0] {StIdle, StAck, StReq, StRead, StLast, StOut} state_e;

    state_e                     state_q, state_d;
    logic [index_width-1:0]     row_q, col_q, mu_q;
    logic [memory_size_log-1:0] a_base_q, b_base_q;
    logic [index_width-1:0]     k_q, k_d;
    logic [CntW-1:0]            n_q, n_d;
    logic                       pend_q;
    logic [CntW-1:0]            pend_line_q;
    logic [BlockW-1:0]          a_buf_q, b_buf_q;

    logic                       take_index;
    logic                       read_en;
    logic                       last;
    logic [ProdW-1:0]           a_sel, b_sel;
    logic [memory_size_log-1:0] line_addr;

    assign take_index = (state_q == StIdle) && bus.in_index_ready;
    assign read_en    = (state_q == StRead) && bus.in_grant;
    assign last       = (state_q == StOut) && (k_q == mu_q - index_width'(1));

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        unique case (state_q)
            StIdle: if (bus.in_index_ready) begin
                state_d = StAck;
                k_d     = '0;
            end
            StAck:  state_d = (mu_q == '0) ? StIdle : StReq;
            StReq:  if (bus.in_grant) begin
                state_d = StRead;
                n_d     = '0;
            end
            StRead: if (bus.in_grant) begin
                n_d = n_q + CntW'(1);
                if (n_q == CntW'(Lines - 1)) state_d = StLast;
            end
            StLast: state_d = StOut;
            StOut:  if (bus.in_block_ready) begin
                if (last) begin
                    state_d = StIdle;
                end else begin
                    k_d     = k_q + index_width'(1);
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Full-width products, then the sum wraps into the line address space
    always_comb begin
        a_sel = ProdW'(row_q) * ProdW'(mu_q) + ProdW'(k_q);
        b_sel = ProdW'(k_q) * ProdW'(mu_q) + ProdW'(col_q);
        if (n_q < CntW'(size)) begin
            line_addr = memory_size_log'(ProdW'(a_base_q) + a_sel * ProdW'(size) + ProdW'(n_q));
        end else begin
            line_addr = memory_size_log'(ProdW'(b_base_q) + b_sel * ProdW'(size)
                                         + ProdW'(n_q - CntW'(size)));
        end
    end

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            state_q     <= StIdle;
            row_q       <= '0;
            col_q       <= '0;
            mu_q        <= '0;
            a_base_q    <= '0;
            b_base_q    <= '0;
            k_q         <= '0;
            n_q         <= '0;
            pend_q      <= 1'b0;
            pend_line_q <= '0;
            a_buf_q     <= '0;
            b_buf_q     <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            n_q         <= n_d;
            pend_q      <= read_en;
            pend_line_q <= n_q;
            if (take_index) begin
                row_q    <= bus.in_row_index;
                col_q    <= bus.in_col_index;
                mu_q     <= bus.in_mu;
                a_base_q <= bus.in_a_base;
                b_base_q <= bus.in_b_base;
            end
            // Read data returns one cycle after its strobe; pend_line_q names its slot
            for (int j = 0; j < int'(size); j++) begin
                if (pend_q && pend_line_q == CntW'(j)) begin
                    a_buf_q[j*LineW +: LineW] <= bus.in_mem_data;
                end
                if (pend_q && pend_line_q == CntW'(j + int'(size))) begin
                    b_buf_q[j*LineW +: LineW] <= bus.in_mem_data;
                end
            end
        end
    end

    assign bus.out_index_ack   = (state_q == StAck);
    assign bus.out_request     = (state_q == StReq) || (state_q == StRead);
    assign bus.out_mem_read_en = read_en;
    assign bus.out_mem_address = read_en ? line_addr : '0;
    assign bus.out_block_valid = (state_q == StOut);
    assign bus.out_a_block     = a_buf_q;
    assign bus.out_b_block     = b_buf_q;
    assign bus.out_k           = k_q;
    assign bus.out_last        = last;
    assign bus.out_busy        = (state_q != StIdle);
endmodule

// File: tb/tb_index_fetch_unit.sv
// Bench for index_fetch_unit: random memory image, directed and random index transactions
// checked against address and block values computed from the fetch rules.
module tb_index_fetch_unit;
    localparam int unsigned Size   = 3;
    localparam int unsigned CellW  = 32;
    localparam int unsigned IdxW   = 8;
    localparam int unsigned AddrW  = 10;
    localparam int unsigned LineW  = Size * CellW;
    localparam int unsigned BlockW = Size * LineW;
    localparam int unsigned Depth  = 1 << AddrW;

    logic in_clk = 1'b0;
    logic in_reset = 1'b0;

    index_fetch_unit_if #(
        .size(Size), .cell_width(CellW), .index_width(IdxW), .memory_size_log(AddrW)
    ) bus ();

    index_fetch_unit #(
        .size(Size), .cell_width(CellW), .index_width(IdxW), .memory_size_log(AddrW)
    ) dut (
        .in_clk   (in_clk),
        .in_reset (in_reset),
        .bus      (bus)
    );

    initial forever #5 in_clk = ~in_clk;

    logic [LineW-1:0] mem [Depth];
    logic [AddrW-1:0] addr_log [$];
    int vectors = 0;
    int miscompares = 0;
    int read_cnt = 0;
    int req_cnt = 0;
    int bad_grant_read = 0;
    int bad_idle_addr = 0;
    int grant_mode = 0;
    int gap_at = -1;

    // Memory answers one cycle after the strobe
    always @(posedge in_clk) begin
        if (bus.out_mem_read_en) bus.in_mem_data <= mem[bus.out_mem_address];
    end

    always @(posedge in_clk) begin
        if (bus.out_mem_read_en) begin
            addr_log.push_back(bus.out_mem_address);
            read_cnt = read_cnt + 1;
            if (!bus.in_grant) bad_grant_read = bad_grant_read + 1;
        end else if (bus.out_mem_address !== '0) begin
            bad_idle_addr = bad_idle_addr + 1;
        end
        if (bus.out_request) req_cnt = req_cnt + 1;
    end

    // Grant: 0 tied high, 1 random, 2 a three-cycle gap once read_cnt reaches gap_at
    initial begin
        int dropped;
        int seen_at;
        dropped = 0;
        seen_at = -1;
        bus.in_grant = 1'b1;
        forever begin
            @(negedge in_clk);
            if (gap_at != seen_at) begin
                dropped = 0;
                seen_at = gap_at;
            end
            if (grant_mode == 1) begin
                bus.in_grant = ($urandom_range(0, 2) != 0);
            end else if (grant_mode == 2 && read_cnt == gap_at && dropped < 3) begin
                bus.in_grant = 1'b0;
                dropped = dropped + 1;
            end else begin
                bus.in_grant = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [BlockW-1:0] obs,
                         input logic [BlockW-1:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_addr(input int row, input int col, input int mu, input int ab,
                                    input int bb, input int k, input int n);
        if (n < int'(Size)) return (ab + (row * mu + k) * int'(Size) + n) % int'(Depth);
        return (bb + (k * mu + col) * int'(Size) + n - int'(Size)) % int'(Depth);
    endfunction

    task automatic offer_index(input int row, input int col, input int mu, input int ab,
                               input int bb);
        @(negedge in_clk);
        bus.in_index_ready = 1'b1;
        bus.in_row_index   = IdxW'(row);
        bus.in_col_index   = IdxW'(col);
        bus.in_mu          = IdxW'(mu);
        bus.in_a_base      = AddrW'(ab);
        bus.in_b_base      = AddrW'(bb);
        @(negedge in_clk);
        bus.in_index_ready = 1'b0;
        bus.in_row_index   = IdxW'($urandom);
        bus.in_col_index   = IdxW'($urandom);
        bus.in_mu          = IdxW'($urandom);
        bus.in_a_base      = AddrW'($urandom);
        bus.in_b_base      = AddrW'($urandom);
    endtask

    task automatic run_txn(input int row, input int col, input int mu, input int ab,
                           input int bb, input int bp, input bit check_lat);
        int lat;
        int log_base;
        int req_base;
        bit timeout;
        logic [BlockW-1:0] exp_a, exp_b;
        req_base = req_cnt;
        log_base = addr_log.size();
        offer_index(row, col, mu, ab, bb);
        check("ack_pulse", BlockW'(bus.out_index_ack), BlockW'(1));
        check("busy_after_ack", BlockW'(bus.out_busy), BlockW'(1));
        @(negedge in_clk);
        lat = 1;
        check("ack_single", BlockW'(bus.out_index_ack), BlockW'(0));
        if (mu == 0) begin
            repeat (3) @(negedge in_clk);
            check("mu0_idle", BlockW'(bus.out_busy), BlockW'(0));
            check("mu0_no_request", BlockW'(req_cnt - req_base), BlockW'(0));
            return;
        end
        for (int k = 0; k < mu; k++) begin
            timeout = 1'b1;
            for (int c = 0; c < 400; c++) begin
                if (bus.out_block_valid) begin
                    timeout = 1'b0;
                    break;
                end
                @(negedge in_clk);
                lat = lat + 1;
            end
            check("valid_timeout", BlockW'(timeout), BlockW'(0));
            if (timeout) return;
            if (check_lat && k == 0) check("latency", BlockW'(lat), BlockW'(2 * Size + 3));
            check("read_count", BlockW'(addr_log.size() - log_base), BlockW'(2 * Size));
            for (int n = 0; n < int'(2 * Size); n++) begin
                if (log_base + n < addr_log.size()) begin
                    check("read_addr", BlockW'(addr_log[log_base + n]),
                          BlockW'(exp_addr(row, col, mu, ab, bb, k, n)));
                end
            end
            for (int j = 0; j < int'(Size); j++) begin
                exp_a[j*LineW +: LineW] = mem[exp_addr(row, col, mu, ab, bb, k, j)];
                exp_b[j*LineW +: LineW] = mem[exp_addr(row, col, mu, ab, bb, k, j + int'(Size))];
            end
            check("a_block", bus.out_a_block, exp_a);
            check("b_block", bus.out_b_block, exp_b);
            check("out_k", BlockW'(bus.out_k), BlockW'(k));
            check("out_last", BlockW'(bus.out_last), BlockW'(k == mu - 1));
            log_base = addr_log.size();
            for (int i = 0; i < bp; i++) begin
                @(negedge in_clk);
                check("bp_valid", BlockW'(bus.out_block_valid), BlockW'(1));
                check("bp_no_request", BlockW'(bus.out_request), BlockW'(0));
                check("bp_a_stable", bus.out_a_block, exp_a);
                check("bp_b_stable", bus.out_b_block, exp_b);
            end
            bus.in_block_ready = 1'b1;
            @(negedge in_clk);
            bus.in_block_ready = 1'b0;
            lat = 0;
            check("valid_dropped", BlockW'(bus.out_block_valid), BlockW'(0));
            if (k == mu - 1) check("idle_at_end", BlockW'(bus.out_busy), BlockW'(0));
            else check("next_request", BlockW'(bus.out_request), BlockW'(1));
        end
        check("grant_respected", BlockW'(bad_grant_read), BlockW'(0));
        check("idle_addr_zero", BlockW'(bad_idle_addr), BlockW'(0));
    endtask

    initial begin
        int base;
        bit timeout;
        bus.in_index_ready = 1'b0;
        bus.in_row_index   = '0;
        bus.in_col_index   = '0;
        bus.in_mu          = '0;
        bus.in_a_base      = '0;
        bus.in_b_base      = '0;
        bus.in_block_ready = 1'b0;
        for (int i = 0; i < int'(Depth); i++) mem[i] = {$urandom(), $urandom(), $urandom()};

        repeat (2) @(negedge in_clk);
        check("reset_ctrl", BlockW'({bus.out_index_ack, bus.out_request, bus.out_mem_read_en,
                                     bus.out_block_valid, bus.out_last, bus.out_busy}),
              BlockW'(0));
        check("reset_k", BlockW'(bus.out_k), BlockW'(0));
        check("reset_a_block", bus.out_a_block, BlockW'(0));
        in_reset = 1'b1;

        // Basic fetch with grant tied high, including the index-to-valid latency
        run_txn(1, 0, 2, 0, 100, 0, 1'b1);

        // Grant gap after the second read
        gap_at = read_cnt + 2;
        grant_mode = 2;
        run_txn(2, 1, 2, 50, 300, 0, 1'b0);
        grant_mode = 0;

        // Backpressure in OUT
        run_txn(0, 1, 2, 10, 500, 5, 1'b0);

        // mu == 0
        run_txn(3, 3, 0, 0, 0, 0, 1'b0);

        // Reset while two lines have been issued
        base = read_cnt;
        offer_index(1, 2, 3, 700, 800);
        timeout = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge in_clk);
            if (read_cnt == base + 2) begin
                timeout = 1'b0;
                break;
            end
        end
        check("reset_wait_timeout", BlockW'(timeout), BlockW'(0));
        in_reset = 1'b0;
        #1;
        check("midreset_ctrl", BlockW'({bus.out_index_ack, bus.out_request, bus.out_mem_read_en,
                                        bus.out_block_valid, bus.out_last, bus.out_busy}),
              BlockW'(0));
        check("midreset_addr", BlockW'(bus.out_mem_address), BlockW'(0));
        check("midreset_a_block", bus.out_a_block, BlockW'(0));
        check("midreset_b_block", bus.out_b_block, BlockW'(0));
        @(negedge in_clk);
        in_reset = 1'b1;
        run_txn(1, 1, 2, 200, 400, 0, 1'b0);

        // Address wrap at the top of memory
        run_txn(0, 0, 1, 1020, 1023, 0, 1'b0);

        // Random transactions, random grant
        for (int t = 0; t < 8; t++) begin
            grant_mode = int'($urandom_range(0, 1));
            run_txn(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(1, 3)), int'($urandom_range(0, Depth - 1)),
                    int'($urandom_range(0, Depth - 1)), int'($urandom_range(0, 3)), 1'b0);
        end
        grant_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
